serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_if.sv | 25 ++
 rtl/serial_adder_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Operand/handshake bundle for the bit-serial adder/subtractor.
// The requester drives the master side; the adder implements the slave side.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, op_a, op_b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one full-adder cell reused LSB first over WIDTH cycles.
// Subtraction is a + ~b + 1, with the +1 entering as the initial carry.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic accept;
  logic last_bit;
  logic sum_bit;
  logic carry_out;

  assign accept    = (state_q == StIdle) && bus.start;
  assign last_bit  = (state_q == StRun) && (cnt_q == CntW'(WIDTH - 1));
  assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_out = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state_q)
      StRun:   bus.busy = 1'b1;
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: accumulator collects sum bits from the MSB end; result only moves at completion.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    if (accept) begin
      a_d      = bus.op_a;
      b_d      = bus.sub ? ~bus.op_b : bus.op_b;
      carry_d  = bus.sub;
      cnt_d    = '0;
      acc_d    = '0;
      result_d = '0;
      cout_d   = 1'b0;
      ovf_d    = 1'b0;
    end else if (state_q == StRun) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
      carry_d = carry_out;
      cnt_d   = cnt_q + CntW'(1);
      if (last_bit) begin
        result_d = {sum_bit, acc_q[WIDTH-1:1]};
        cout_d   = carry_out;
        // carry_q here is the carry into the MSB cell
        ovf_d    = carry_q ^ carry_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed corner cases plus random operations,
// checked against an arithmetic reference model with exact cycle timing.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;
  int   done_cyc;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input longint a, input longint b, input bit s,
                                output longint r, output bit c, output bit v);
    longint m;
    longint sa;
    longint sb;
    longint sr;
    m  = longint'(1) << W;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (s) begin
      r  = (a - b + m) % m;
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      r  = (a + b) % m;
      c  = ((a + b) >= m);
      sr = sa + sb;
    end
    v = (sr > m / 2 - 1) || (sr < -(m / 2));
  endfunction

  // Caller is at a negedge with the DUT idle; start is accepted at the next posedge.
  // hold keeps start high throughout; poke raises a second start with new operands mid-run.
  task automatic op(input longint a, input longint b, input bit s, input bit hold,
                    input bit poke);
    longint r;
    bit     c;
    bit     v;
    model(a, b, s, r, c, v);
    bus.start = 1'b1;
    bus.op_a  = W'(a);
    bus.op_b  = W'(b);
    bus.sub   = s;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = hold;
      if (poke && i == 2) bus.start = 1'b1;
      if (poke && i == 5) bus.start = 1'b0;
      bus.op_a = W'($urandom);
      bus.op_b = W'($urandom);
      bus.sub  = 1'($urandom);
      chk("run_busy_done", {62'd0, bus.busy, bus.done}, 64'b10);
      chk("run_result_hidden", 64'(bus.result), 64'd0);
    end
    @(negedge clk);
    done_cyc = cyc;
    chk("done_phase", {62'd0, bus.busy, bus.done}, 64'b01);
    chk("result", 64'(bus.result), 64'(r));
    chk("cout", 64'(bus.cout), 64'(c));
    chk("ovf", 64'(bus.ovf), 64'(v));
    if (!hold) bus.start = 1'b0;
    bus.op_a = W'($urandom);
    bus.op_b = W'($urandom);
    @(negedge clk);
    chk("idle_phase", {62'd0, bus.busy, bus.done}, 64'b00);
    chk("result_held", 64'(bus.result), 64'(r));
    if (poke) begin
      @(negedge clk);
      chk("no_second_op", {62'd0, bus.busy, bus.done}, 64'b00);
    end
  endtask

  initial begin
    int d1;
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    done_cyc  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'b00);
    chk("reset_result", 64'(bus.result), 64'd0);
    chk("reset_flags", {62'd0, bus.cout, bus.ovf}, 64'b00);

    // Start in the first cycle after reset deasserts.
    rst = 1'b0;
    op(64'h0F, 64'h01, 1'b0, 1'b0, 1'b0);
    op(64'hFF, 64'h01, 1'b0, 1'b0, 1'b0);
    op(64'h7F, 64'h01, 1'b0, 1'b0, 1'b0);

    // Reset while idle clears the held result/flags.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("idle_reset_result", 64'(bus.result), 64'd0);
    chk("idle_reset_flags", {62'd0, bus.cout, bus.ovf}, 64'b00);

    op(64'h05, 64'h07, 1'b1, 1'b0, 1'b0);
    op(64'h80, 64'h01, 1'b1, 1'b0, 1'b0);

    // Second start during RUN is ignored.
    op(64'h21, 64'h13, 1'b0, 1'b0, 1'b1);

    // Reset in the 4th busy cycle, with start also high: reset wins.
    bus.start = 1'b1;
    bus.op_a  = 8'h0F;
    bus.op_b  = 8'h01;
    bus.sub   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("pre_reset_busy", 64'(bus.busy), 64'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy_done", {62'd0, bus.busy, bus.done}, 64'b00);
    chk("abort_result", 64'(bus.result), 64'd0);
    chk("abort_flags", {62'd0, bus.cout, bus.ovf}, 64'b00);
    op(64'h0F, 64'h01, 1'b0, 1'b0, 1'b0);

    // Back-to-back with start held high.
    op(64'h3C, 64'h55, 1'b0, 1'b1, 1'b0);
    d1 = done_cyc;
    op(64'h10, 64'h9A, 1'b1, 1'b1, 1'b0);
    chk("b2b_spacing", 64'(done_cyc - d1), 64'(W + 2));
    d1 = done_cyc;
    op(64'hC8, 64'hC8, 1'b0, 1'b0, 1'b0);
    chk("b2b_spacing2", 64'(done_cyc - d1), 64'(W + 2));

    // Random operations.
    for (int n = 0; n < 24; n++) begin
      op(longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)),
         1'($urandom), 1'($urandom), 1'b0);
    end
    bus.start = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
